// File: rtl/frame_select_pkg.sv
// Shared definitions for the column frame-strobe logic: FSM state encodings
// and the default "all columns" select value.
package frame_select_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  // The broadcast select defaults to the all-ones value of the select bus.
  function automatic int default_broadcast_sel(input int sel_width);
    return (1 << sel_width) - 1;
  endfunction

endpackage

// File: rtl/strobe_hold_timer.sv
// Loadable down-counter with a zero flag; stops at zero rather than wrapping.
module strobe_hold_timer #(
  parameter int Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [Width-1:0] load_val,
  input  logic             dec_en,
  output logic [Width-1:0] count,
  output logic             zero
);

  logic [Width-1:0] count_d;
  logic [Width-1:0] count_q;

  // Load has priority over decrement; decrement never goes below zero.
  always_comb begin
    count_d = count_q;
    if (load_en) begin
      count_d = load_val;
    end else if (dec_en && (count_q != '0)) begin
      count_d = count_q - Width'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/frame_strobe_pulse.sv
// Per-column frame-strobe pulse generator: decodes the column (or broadcast)
// select, latches the strobe vector, holds it for PulseCycles cycles, then
// forces a one-cycle zero gap. Reports busy, sticky overrun and a saturating
// accepted-frame count. All outputs come straight from flops.
module frame_strobe_pulse
  import frame_select_pkg::*;
#(
  parameter int MaxFramesPerCol  = 20,
  parameter int FrameSelectWidth = 7,
  parameter int Col              = 18,
  parameter int PulseCycles      = 1,
  parameter int BroadcastEn      = 1,
  parameter int BroadcastSel     = default_broadcast_sel(FrameSelectWidth),
  parameter int CountWidth       = 16
) (
  input  logic                        CLK,
  input  logic                        resetn,
  input  logic [MaxFramesPerCol-1:0]  FrameStrobe_I,
  input  logic [FrameSelectWidth-1:0] FrameSelect,
  input  logic                        FrameStrobe,
  input  logic                        Clear,
  output logic [MaxFramesPerCol-1:0]  FrameStrobe_O,
  output logic                        Busy,
  output logic                        Overrun,
  output logic [CountWidth-1:0]       FrameCount
);

  localparam int HoldWidth = (PulseCycles > 1) ? $clog2(PulseCycles) : 1;
  localparam logic [HoldWidth-1:0]        HoldLoad = HoldWidth'(PulseCycles - 1);
  localparam logic [FrameSelectWidth-1:0] ColSel   = FrameSelectWidth'(Col);
  localparam logic [FrameSelectWidth-1:0] BcastSel = FrameSelectWidth'(BroadcastSel);
  localparam logic                        BcastOn  = (BroadcastEn != 0);

  // Reject configurations that cannot work: a zero-length pulse, or a column
  // index that collides with the broadcast value.
  if (PulseCycles < 1) begin : g_bad_pulse
    $fatal(1, "frame_strobe_pulse: PulseCycles must be at least 1");
  end
  if (Col == BroadcastSel) begin : g_bad_col
    $fatal(1, "frame_strobe_pulse: Col must differ from BroadcastSel");
  end

  state_e                     state_d, state_q;
  logic [MaxFramesPerCol-1:0] strobe_d, strobe_q;
  logic                       busy_d, busy_q;
  logic                       overrun_d, overrun_q;
  logic [CountWidth-1:0]      count_d, count_q;

  logic                       match;
  logic                       has_vec;
  logic                       accept;
  logic                       drop;
  logic                       timer_load;
  logic                       timer_dec;
  logic                       timer_zero;
  logic [HoldWidth-1:0]       timer_count;

  // Request decode. The GAP cycle is the last cycle of the previous pulse, so
  // a request sampled there starts the next pulse straight away; the output
  // is still zero for that whole GAP cycle, which keeps the guard gap intact.
  always_comb begin
    match   = FrameStrobe &&
              ((FrameSelect == ColSel) || (BcastOn && (FrameSelect == BcastSel)));
    has_vec = |FrameStrobe_I;
    accept  = match && has_vec && ((state_q == ST_IDLE) || (state_q == ST_GAP));
    drop    = match && has_vec && (state_q == ST_HOLD);
  end

  // Next-state logic for the pulse FSM and its registered outputs.
  always_comb begin
    state_d    = state_q;
    strobe_d   = strobe_q;
    timer_load = 1'b0;
    timer_dec  = 1'b0;
    case (state_q)
      ST_IDLE, ST_GAP: begin
        if (accept) begin
          strobe_d   = FrameStrobe_I;
          state_d    = ST_HOLD;
          timer_load = 1'b1;
        end else begin
          strobe_d = '0;
          state_d  = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (timer_zero) begin
          strobe_d = '0;
          state_d  = ST_GAP;
        end else begin
          timer_dec = 1'b1;
        end
      end
      default: begin
        strobe_d = '0;
        state_d  = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Status: Clear wins over both the counter increment and an overrun set.
  always_comb begin
    overrun_d = overrun_q;
    count_d   = count_q;
    if (Clear) begin
      overrun_d = 1'b0;
      count_d   = '0;
    end else begin
      overrun_d = overrun_q | drop;
      if (accept && (count_q != '1)) begin
        count_d = count_q + CountWidth'(1);
      end
    end
  end

  // All state and output registers.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      strobe_q  <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
    end
  end

  strobe_hold_timer #(
    .Width(HoldWidth)
  ) u_hold_timer (
    .clk     (CLK),
    .rst_n   (resetn),
    .load_en (timer_load),
    .load_val(HoldLoad),
    .dec_en  (timer_dec),
    .count   (timer_count),
    .zero    (timer_zero)
  );

  assign FrameStrobe_O = strobe_q;
  assign Busy          = busy_q;
  assign Overrun       = overrun_q;
  assign FrameCount    = count_q;

endmodule

// File: tb/tb_frame_strobe_pulse.sv
// Directed bench for frame_strobe_pulse. Four instances with different
// parameters share the same input bus; each scenario checks the instance
// whose configuration it targets.
module tb_frame_strobe_pulse;

  logic        CLK;
  logic        resetn;
  logic [19:0] FrameStrobe_I;
  logic [6:0]  FrameSelect;
  logic        FrameStrobe;
  logic        Clear;

  logic [19:0] o_p1, o_p3, o_p2, o_p4;
  logic        b_p1, b_p3, b_p2, b_p4;
  logic        ov_p1, ov_p3, ov_p2, ov_p4;
  logic [15:0] c_p1, c_p3, c_p4;
  logic [1:0]  c_p2;

  int pass_cnt  = 0;
  int check_cnt = 0;

  frame_strobe_pulse #(.PulseCycles(1)) u_p1 (
    .CLK(CLK), .resetn(resetn), .FrameStrobe_I(FrameStrobe_I), .FrameSelect(FrameSelect),
    .FrameStrobe(FrameStrobe), .Clear(Clear), .FrameStrobe_O(o_p1), .Busy(b_p1),
    .Overrun(ov_p1), .FrameCount(c_p1));

  frame_strobe_pulse #(.PulseCycles(3)) u_p3 (
    .CLK(CLK), .resetn(resetn), .FrameStrobe_I(FrameStrobe_I), .FrameSelect(FrameSelect),
    .FrameStrobe(FrameStrobe), .Clear(Clear), .FrameStrobe_O(o_p3), .Busy(b_p3),
    .Overrun(ov_p3), .FrameCount(c_p3));

  frame_strobe_pulse #(.PulseCycles(2), .BroadcastEn(0), .CountWidth(2)) u_p2 (
    .CLK(CLK), .resetn(resetn), .FrameStrobe_I(FrameStrobe_I), .FrameSelect(FrameSelect),
    .FrameStrobe(FrameStrobe), .Clear(Clear), .FrameStrobe_O(o_p2), .Busy(b_p2),
    .Overrun(ov_p2), .FrameCount(c_p2));

  frame_strobe_pulse #(.PulseCycles(4)) u_p4 (
    .CLK(CLK), .resetn(resetn), .FrameStrobe_I(FrameStrobe_I), .FrameSelect(FrameSelect),
    .FrameStrobe(FrameStrobe), .Clear(Clear), .FrameStrobe_O(o_p4), .Busy(b_p4),
    .Overrun(ov_p4), .FrameCount(c_p4));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    FrameStrobe_I = '0;
    FrameSelect   = '0;
    FrameStrobe   = 1'b0;
    Clear         = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    resetn = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
  endtask

  task automatic request(input logic [6:0] sel, input logic [19:0] vec);
    FrameSelect   = sel;
    FrameStrobe_I = vec;
    FrameStrobe   = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    check_cnt++; if (o_p1 !== 20'h0) $display("[TB] FAIL reset_out: got %h expected %h", o_p1, 20'h0); else pass_cnt++;
    check_cnt++; if (b_p1 !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", b_p1); else pass_cnt++;
    check_cnt++; if (ov_p4 !== 1'b0) $display("[TB] FAIL reset_overrun: got %b expected 0", ov_p4); else pass_cnt++;
    check_cnt++; if (c_p4 !== 16'd0) $display("[TB] FAIL reset_count: got %0d expected 0", c_p4); else pass_cnt++;
  endtask

  task automatic test_pulse1();
    do_reset();
    request(7'd18, 20'h00004);
    tick();
    FrameStrobe = 1'b0;
    check_cnt++; if (o_p1 !== 20'h00004) $display("[TB] FAIL p1_out_on: got %h expected %h", o_p1, 20'h00004); else pass_cnt++;
    check_cnt++; if (b_p1 !== 1'b1) $display("[TB] FAIL p1_busy_on: got %b expected 1", b_p1); else pass_cnt++;
    tick();
    check_cnt++; if (o_p1 !== 20'h0) $display("[TB] FAIL p1_out_gap: got %h expected %h", o_p1, 20'h0); else pass_cnt++;
    check_cnt++; if (b_p1 !== 1'b1) $display("[TB] FAIL p1_busy_gap: got %b expected 1", b_p1); else pass_cnt++;
    tick();
    check_cnt++; if (b_p1 !== 1'b0) $display("[TB] FAIL p1_busy_done: got %b expected 0", b_p1); else pass_cnt++;
    check_cnt++; if (c_p1 !== 16'd1) $display("[TB] FAIL p1_count: got %0d expected 1", c_p1); else pass_cnt++;
  endtask

  task automatic test_hold3();
    do_reset();
    request(7'd18, 20'h80001);
    tick();
    FrameStrobe   = 1'b0;
    FrameStrobe_I = 20'h12345;
    check_cnt++; if (o_p3 !== 20'h80001) $display("[TB] FAIL p3_out_c0: got %h expected %h", o_p3, 20'h80001); else pass_cnt++;
    for (int i = 1; i < 3; i++) begin
      tick();
      check_cnt++; if (o_p3 !== 20'h80001) $display("[TB] FAIL p3_out_c%0d: got %h expected %h", i, o_p3, 20'h80001); else pass_cnt++;
    end
    tick();
    check_cnt++; if (o_p3 !== 20'h0) $display("[TB] FAIL p3_out_gap: got %h expected %h", o_p3, 20'h0); else pass_cnt++;
    check_cnt++; if (b_p3 !== 1'b1) $display("[TB] FAIL p3_busy_gap: got %b expected 1", b_p3); else pass_cnt++;
    tick();
    check_cnt++; if (b_p3 !== 1'b0) $display("[TB] FAIL p3_busy_idle: got %b expected 0", b_p3); else pass_cnt++;
    request(7'd17, 20'h00001);
    tick();
    FrameStrobe = 1'b0;
    check_cnt++; if (o_p3 !== 20'h0) $display("[TB] FAIL p3_other_col_out: got %h expected %h", o_p3, 20'h0); else pass_cnt++;
    check_cnt++; if (b_p3 !== 1'b0) $display("[TB] FAIL p3_other_col_busy: got %b expected 0", b_p3); else pass_cnt++;
    check_cnt++; if (c_p3 !== 16'd1) $display("[TB] FAIL p3_other_col_count: got %0d expected 1", c_p3); else pass_cnt++;
  endtask

  task automatic test_broadcast();
    do_reset();
    request(7'd127, 20'h00010);
    tick();
    FrameStrobe = 1'b0;
    check_cnt++; if (o_p1 !== 20'h00010) $display("[TB] FAIL bcast_on_out: got %h expected %h", o_p1, 20'h00010); else pass_cnt++;
    check_cnt++; if (o_p2 !== 20'h0) $display("[TB] FAIL bcast_off_out: got %h expected %h", o_p2, 20'h0); else pass_cnt++;
    check_cnt++; if (b_p2 !== 1'b0) $display("[TB] FAIL bcast_off_busy: got %b expected 0", b_p2); else pass_cnt++;
    check_cnt++; if (c_p1 !== 16'd1) $display("[TB] FAIL bcast_on_count: got %0d expected 1", c_p1); else pass_cnt++;
    check_cnt++; if (c_p2 !== 2'd0) $display("[TB] FAIL bcast_off_count: got %0d expected 0", c_p2); else pass_cnt++;
  endtask

  task automatic test_overrun();
    do_reset();
    request(7'd18, 20'h00003);
    tick();
    FrameStrobe_I = 20'h00005;
    tick();
    FrameStrobe = 1'b0;
    check_cnt++; if (ov_p2 !== 1'b1) $display("[TB] FAIL ovr_flag: got %b expected 1", ov_p2); else pass_cnt++;
    check_cnt++; if (o_p2 !== 20'h00003) $display("[TB] FAIL ovr_inflight: got %h expected %h", o_p2, 20'h00003); else pass_cnt++;
    check_cnt++; if (c_p2 !== 2'd1) $display("[TB] FAIL ovr_count1: got %0d expected 1", c_p2); else pass_cnt++;
    tick();
    check_cnt++; if (o_p2 !== 20'h0) $display("[TB] FAIL ovr_gap: got %h expected %h", o_p2, 20'h0); else pass_cnt++;
    request(7'd18, 20'h00009);
    tick();
    FrameStrobe = 1'b0;
    check_cnt++; if (o_p2 !== 20'h00009) $display("[TB] FAIL ovr_second_out: got %h expected %h", o_p2, 20'h00009); else pass_cnt++;
    check_cnt++; if (c_p2 !== 2'd2) $display("[TB] FAIL ovr_count2: got %0d expected 2", c_p2); else pass_cnt++;
    tick();
    tick();
    tick();
    check_cnt++; if (b_p2 !== 1'b0) $display("[TB] FAIL ovr_busy_end: got %b expected 0", b_p2); else pass_cnt++;
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    check_cnt++; if (ov_p2 !== 1'b0) $display("[TB] FAIL clr_overrun: got %b expected 0", ov_p2); else pass_cnt++;
    check_cnt++; if (c_p2 !== 2'd0) $display("[TB] FAIL clr_count: got %0d expected 0", c_p2); else pass_cnt++;
  endtask

  task automatic test_clear_accept();
    do_reset();
    Clear = 1'b1;
    request(7'd18, 20'h00040);
    tick();
    Clear       = 1'b0;
    FrameStrobe = 1'b0;
    check_cnt++; if (o_p1 !== 20'h00040) $display("[TB] FAIL clracc_out: got %h expected %h", o_p1, 20'h00040); else pass_cnt++;
    check_cnt++; if (c_p1 !== 16'd0) $display("[TB] FAIL clracc_count: got %0d expected 0", c_p1); else pass_cnt++;
  endtask

  task automatic test_zero_and_saturation();
    logic [1:0] exp_cnt;
    do_reset();
    request(7'd18, 20'h00000);
    tick();
    FrameStrobe = 1'b0;
    check_cnt++; if (b_p2 !== 1'b0) $display("[TB] FAIL zero_vec_busy: got %b expected 0", b_p2); else pass_cnt++;
    check_cnt++; if (c_p2 !== 2'd0) $display("[TB] FAIL zero_vec_count: got %0d expected 0", c_p2); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
      request(7'd18, 20'h00100);
      tick();
      FrameStrobe = 1'b0;
      check_cnt++; if (c_p2 !== exp_cnt) $display("[TB] FAIL sat_count_%0d: got %0d expected %0d", i, c_p2, exp_cnt); else pass_cnt++;
      tick();
      tick();
    end
    check_cnt++; if (ov_p2 !== 1'b0) $display("[TB] FAIL sat_no_overrun: got %b expected 0", ov_p2); else pass_cnt++;
  endtask

  task automatic test_reset_mid_hold();
    do_reset();
    request(7'd18, 20'h000AA);
    tick();
    FrameStrobe = 1'b0;
    tick();
    tick();
    check_cnt++; if (o_p4 !== 20'h000AA) $display("[TB] FAIL rmh_before: got %h expected %h", o_p4, 20'h000AA); else pass_cnt++;
    #2;
    resetn = 1'b0;
    #1;
    check_cnt++; if (o_p4 !== 20'h0) $display("[TB] FAIL rmh_async_out: got %h expected %h", o_p4, 20'h0); else pass_cnt++;
    check_cnt++; if (b_p4 !== 1'b0) $display("[TB] FAIL rmh_async_busy: got %b expected 0", b_p4); else pass_cnt++;
    check_cnt++; if (c_p4 !== 16'd0) $display("[TB] FAIL rmh_async_count: got %0d expected 0", c_p4); else pass_cnt++;
    request(7'd18, 20'h0003C);
    #1;
    resetn = 1'b1;
    tick();
    FrameStrobe = 1'b0;
    check_cnt++; if (o_p4 !== 20'h0003C) $display("[TB] FAIL rmh_first_out: got %h expected %h", o_p4, 20'h0003C); else pass_cnt++;
    check_cnt++; if (c_p4 !== 16'd1) $display("[TB] FAIL rmh_first_count: got %0d expected 1", c_p4); else pass_cnt++;
    for (int i = 1; i < 4; i++) begin
      tick();
      check_cnt++; if (o_p4 !== 20'h0003C) $display("[TB] FAIL rmh_hold_c%0d: got %h expected %h", i, o_p4, 20'h0003C); else pass_cnt++;
    end
    tick();
    check_cnt++; if (o_p4 !== 20'h0) $display("[TB] FAIL rmh_gap: got %h expected %h", o_p4, 20'h0); else pass_cnt++;
    check_cnt++; if (b_p4 !== 1'b1) $display("[TB] FAIL rmh_gap_busy: got %b expected 1", b_p4); else pass_cnt++;
  endtask

  initial begin
    resetn = 1'b0;
    idle_inputs();
    test_reset();
    test_pulse1();
    test_hold3();
    test_broadcast();
    test_overrun();
    test_clear_accept();
    test_zero_and_saturation();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
